// File: rtl/active_list_queue_pkg.sv
// ---------------------------------------------------------------------------
// ActiveListTypes
// Shared definitions for the active list (in-order retirement queue):
//   - queue geometry constants (depth, rename and commit widths)
//   - pointer types without and with the wrap bit, and the occupancy count type
//   - the packed per-op payload; its $bits sets the RAM word width
// No ports; imported by the active list RTL.
// ---------------------------------------------------------------------------
package ActiveListTypes;

    localparam int ACTIVE_LIST_ENTRY_NUM   = 64;
    localparam int RENAME_WIDTH            = 2;
    localparam int COMMIT_WIDTH            = 2;
    localparam int ACTIVE_LIST_INDEX_WIDTH = $clog2(ACTIVE_LIST_ENTRY_NUM);

    // Index into the payload RAM.
    typedef logic [ACTIVE_LIST_INDEX_WIDTH-1:0] ActiveListIndexPath;
    // Index plus wrap bit in the MSB; distinguishes full from empty.
    typedef logic [ACTIVE_LIST_INDEX_WIDTH:0]   ActiveListIndexWrapPath;
    // Occupancy 0..ENTRY_NUM.
    typedef logic [ACTIVE_LIST_INDEX_WIDTH:0]   ActiveListCountPath;

    // Per-op bookkeeping carried from rename to commit (96 bits).
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] brTarget;
        logic [7:0]  opType;
        logic        writeReg;
        logic [4:0]  logDstReg;
        logic [6:0]  phyDstReg;
        logic [6:0]  phyPrevDstReg;
        logic        isBranch;
        logic        isLoad;
        logic        isStore;
        logic        undefined;
    } ActiveListEntry;

    localparam int ACTIVE_LIST_ENTRY_WIDTH = $bits(ActiveListEntry);

endpackage

// File: rtl/active_list_queue_ram.sv
// ---------------------------------------------------------------------------
// multi_port_ring_ram
// Payload storage for the active list.
//   clk      : clock
//   we_i     : per write port enable
//   waddr_i  : per write port index (packed, port 0 in the LSBs)
//   wdata_i  : per write port data  (packed, port 0 in the LSBs)
//   raddr_i  : per read port index
//   rdata_o  : per read port data, combinational (asynchronous) read
// Write ports never collide in normal use (the top hands out distinct
// indices); if they did, the highest-numbered port would win.
// ---------------------------------------------------------------------------
module multi_port_ring_ram
    import ActiveListTypes::*;
#(
    parameter int DEPTH    = ACTIVE_LIST_ENTRY_NUM,
    parameter int WIDTH    = ACTIVE_LIST_ENTRY_WIDTH,
    parameter int WR_PORTS = RENAME_WIDTH,
    parameter int RD_PORTS = COMMIT_WIDTH
) (
    input  logic                               clk,
    input  logic [WR_PORTS-1:0]                we_i,
    input  logic [WR_PORTS*$clog2(DEPTH)-1:0]  waddr_i,
    input  logic [WR_PORTS*WIDTH-1:0]          wdata_i,
    input  logic [RD_PORTS*$clog2(DEPTH)-1:0]  raddr_i,
    output logic [RD_PORTS*WIDTH-1:0]          rdata_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < WR_PORTS; i++) begin
            if (we_i[i]) begin
                mem_q[waddr_i[i*AW +: AW]] <= wdata_i[i*WIDTH +: WIDTH];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < RD_PORTS; gi++) begin : g_rd
            assign rdata_o[gi*WIDTH +: WIDTH] = mem_q[raddr_i[gi*AW +: AW]];
        end
    endgenerate

endmodule

// File: rtl/active_list_queue.sv
// ---------------------------------------------------------------------------
// active_list_queue
// In-order circular queue holding renamed ops from allocation to retirement.
//   clk, rst       : clock, synchronous active-high reset
//   pushTail       : per rename lane push request (lanes may be sparse)
//   pushedTailData : per lane payload
//   pushedTailPtr  : index assigned to each lane (combinational, every lane)
//   allocatable    : at least RENAME_WIDTH free entries (registered state only)
//   validEntryNum  : occupied entry count
//   headData       : entries head+0 .. head+COMMIT_WIDTH-1 (combinational)
//   headValid      : lane k valid iff validEntryNum > k
//   popHeadNum     : entries retired this cycle
//   recover        : roll the tail back to recoverTailPtr (pushes ignored)
//   recoverTailPtr : new tail including wrap bit
// ---------------------------------------------------------------------------
module active_list_queue #(
    parameter int RENAME_WIDTH = ActiveListTypes::RENAME_WIDTH,
    parameter int COMMIT_WIDTH = ActiveListTypes::COMMIT_WIDTH,
    parameter int ENTRY_NUM    = ActiveListTypes::ACTIVE_LIST_ENTRY_NUM,
    parameter int ENTRY_WIDTH  = ActiveListTypes::ACTIVE_LIST_ENTRY_WIDTH
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [RENAME_WIDTH-1:0]                  pushTail,
    input  logic [RENAME_WIDTH*ENTRY_WIDTH-1:0]      pushedTailData,
    output logic [RENAME_WIDTH*$clog2(ENTRY_NUM)-1:0] pushedTailPtr,
    output logic                                     allocatable,
    output logic [$clog2(ENTRY_NUM):0]               validEntryNum,
    output logic [COMMIT_WIDTH*ENTRY_WIDTH-1:0]      headData,
    output logic [COMMIT_WIDTH-1:0]                  headValid,
    input  logic [$clog2(COMMIT_WIDTH):0]            popHeadNum,
    input  logic                                     recover,
    input  logic [$clog2(ENTRY_NUM):0]               recoverTailPtr
);

    localparam int IW = $clog2(ENTRY_NUM);   // RAM index width
    localparam int PW = IW + 1;              // pointer width with wrap bit
    localparam int CW = $clog2(COMMIT_WIDTH) + 1;

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [PW-1:0] count;
    logic [PW-1:0] free_cnt;
    logic [PW-1:0] push_cnt;
    logic [PW-1:0] pop_req;
    logic [PW-1:0] pop_cnt;
    logic [PW-1:0] rec_span;
    logic [PW-1:0] live_span;
    logic          push_ok;
    logic [RENAME_WIDTH-1:0]    ram_we;
    logic [COMMIT_WIDTH*IW-1:0] ram_raddr;

    // Occupancy falls out of modular subtraction; the wrap bit makes
    // "full" (count == ENTRY_NUM) distinct from "empty" (count == 0).
    assign count         = tail_q - head_q;
    assign free_cnt      = PW'(ENTRY_NUM) - count;
    assign validEntryNum = count;
    assign allocatable   = (free_cnt >= PW'(RENAME_WIDTH));

    // Lane i gets tail + (pushes in lower lanes). push_cnt ends as the
    // total number of pushes this cycle.
    always_comb begin
        push_cnt      = '0;
        pushedTailPtr = '0;
        for (int i = 0; i < RENAME_WIDTH; i++) begin
            pushedTailPtr[i*IW +: IW] = tail_q[IW-1:0] + push_cnt[IW-1:0];
            push_cnt = push_cnt + {{(PW-1){1'b0}}, pushTail[i]};
        end
    end

    // An oversized push group is dropped whole rather than partially
    // written, so the tail never points past live data.
    assign push_ok = !recover && (push_cnt <= free_cnt);

    // Illegal over-pop is clamped so the head can never pass the tail.
    assign pop_req = {{(PW-CW){1'b0}}, popHeadNum};
    assign pop_cnt = (pop_req > count) ? count : pop_req;
    assign head_d  = head_q + pop_cnt;

    always_comb begin
        tail_d = tail_q;
        if (recover) begin
            tail_d = recoverTailPtr;
        end else if (push_ok) begin
            tail_d = tail_q + push_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    assign ram_we = pushTail & {RENAME_WIDTH{push_ok & ~rst}};

    generate
        for (genvar gi = 0; gi < COMMIT_WIDTH; gi++) begin : g_head
            assign ram_raddr[gi*IW +: IW] = head_q[IW-1:0] + IW'(gi);
            assign headValid[gi]          = (count > PW'(gi));
        end
    endgenerate

    multi_port_ring_ram #(
        .DEPTH    (ENTRY_NUM),
        .WIDTH    (ENTRY_WIDTH),
        .WR_PORTS (RENAME_WIDTH),
        .RD_PORTS (COMMIT_WIDTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (pushedTailPtr),
        .wdata_i (pushedTailData),
        .raddr_i (ram_raddr),
        .rdata_o (headData)
    );

    // Recovery target must sit between the post-pop head and the current
    // tail; measuring both distances from the new head keeps this modular.
    assign rec_span  = recoverTailPtr - head_d;
    assign live_span = tail_q - head_d;

    a_pop_in_range: assert property (@(posedge clk) disable iff (rst)
        pop_req <= count);
    a_push_fits: assert property (@(posedge clk) disable iff (rst)
        !recover |-> (push_cnt <= free_cnt));
    a_recover_in_range: assert property (@(posedge clk) disable iff (rst)
        recover |-> (rec_span <= live_span));

endmodule

// File: tb/tb_active_list_queue.sv
module tb_active_list_queue;

    logic         clk;
    logic         rst;
    logic [1:0]   pushTail;
    logic [191:0] pushedTailData;
    logic [11:0]  pushedTailPtr;
    logic         allocatable;
    logic [6:0]   validEntryNum;
    logic [191:0] headData;
    logic [1:0]   headValid;
    logic [1:0]   popHeadNum;
    logic         recover;
    logic [6:0]   recoverTailPtr;

    active_list_queue dut (
        .clk            (clk),
        .rst            (rst),
        .pushTail       (pushTail),
        .pushedTailData (pushedTailData),
        .pushedTailPtr  (pushedTailPtr),
        .allocatable    (allocatable),
        .validEntryNum  (validEntryNum),
        .headData       (headData),
        .headValid      (headValid),
        .popHeadNum     (popHeadNum),
        .recover        (recover),
        .recoverTailPtr (recoverTailPtr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          cnt;
        logic [95:0] d0;
        logic [95:0] d1;
        logic [1:0]  dm;
        bit          pchk;
        int          p0;
        int          p1;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;

    function automatic logic [95:0] mkd(input int n);
        return {32'(n) ^ 32'hA5A5_0000, 32'(n * 7 + 1), ~32'(n)};
    endfunction

    task automatic chk(input string tag, input string what,
                       input logic [95:0] act, input logic [95:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s.%s actual=%h required=%h", tag, what, act, req);
    endtask

    // Monitor: once per cycle, mid-cycle, compare the DUT against the
    // oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        logic [1:0] hv;
        if (sb.size() > 0) begin
            e  = sb.pop_front();
            hv = (e.cnt >= 2) ? 2'b11 : ((e.cnt == 1) ? 2'b01 : 2'b00);
            chk(e.tag, "validEntryNum", 96'(validEntryNum), 96'(e.cnt));
            chk(e.tag, "allocatable", 96'(allocatable), 96'((64 - e.cnt) >= 2));
            chk(e.tag, "headValid", 96'(headValid), 96'(hv));
            if (e.dm[0]) chk(e.tag, "headData0", headData[95:0], e.d0);
            if (e.dm[1]) chk(e.tag, "headData1", headData[191:96], e.d1);
            if (e.pchk) begin
                chk(e.tag, "ptr0", 96'(pushedTailPtr[5:0]), 96'(e.p0));
                chk(e.tag, "ptr1", 96'(pushedTailPtr[11:6]), 96'(e.p1));
            end
            $display("txn %-10s cnt=%0d alloc=%b hv=%b ptr=%0d,%0d",
                     e.tag, validEntryNum, allocatable, headValid,
                     pushedTailPtr[5:0], pushedTailPtr[11:6]);
        end
    end

    task automatic ex(input string tag, input int cnt,
                      input logic [95:0] d0, input logic [95:0] d1,
                      input logic [1:0] dm, input bit pchk,
                      input int p0, input int p1);
        exp_t e;
        e.tag = tag; e.cnt = cnt; e.d0 = d0; e.d1 = d1; e.dm = dm;
        e.pchk = pchk; e.p0 = p0; e.p1 = p1;
        sb.push_back(e);
    endtask

    task automatic cy(input logic [1:0] p, input logic [95:0] a,
                      input logic [95:0] b, input int pop,
                      input logic rc = 1'b0, input int rp = 0,
                      input logic r = 1'b0);
        pushTail       = p;
        pushedTailData = {b, a};
        popHeadNum     = 2'(pop);
        recover        = rc;
        recoverTailPtr = 7'(rp);
        rst            = r;
        @(posedge clk);
        #1;
    endtask

    logic [95:0] A, B, C, P, Q, X, Y, Z0, Z1, NUL;

    initial begin
        A = mkd(1000); B = mkd(1001); C = mkd(1002);
        P = mkd(4000); Q = mkd(4001);
        X = mkd(5000); Y = mkd(5001);
        Z0 = mkd(6000); Z1 = mkd(6001);
        NUL = '0;

        rst = 1'b1; pushTail = '0; pushedTailData = '0;
        popHeadNum = '0; recover = 1'b0; recoverTailPtr = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic push / sparse push / pop
        ex("rst",    0, NUL, NUL, 2'b00, 1, 0, 1); cy(2'b11, A, B, 0);
        ex("pushAB", 2, A,   B,   2'b11, 1, 2, 2); cy(2'b10, NUL, C, 0);
        ex("pushC",  3, A,   B,   2'b11, 0, 0, 0); cy(2'b00, NUL, NUL, 0);
        ex("hold",   3, A,   B,   2'b11, 0, 0, 0); cy(2'b00, NUL, NUL, 2);
        ex("pop2",   1, C,   NUL, 2'b01, 0, 0, 0); cy(2'b00, NUL, NUL, 1);
        ex("empty",  0, NUL, NUL, 2'b00, 1, 3, 3); cy(2'b00, NUL, NUL, 0);

        // Fill to 63 entries from head 3
        for (int i = 0; i <= 30; i++) begin
            ex("fill", 2 * i, NUL, NUL, 2'b00, 1, (3 + 2 * i) % 64, (4 + 2 * i) % 64);
            cy(2'b11, mkd(2000 + 2 * i), mkd(2001 + 2 * i), 0);
        end
        ex("fill1", 62, mkd(2000), mkd(2001), 2'b11, 1, 1, 2);
        cy(2'b01, mkd(2062), NUL, 0);
        ex("full63", 63, mkd(2000), mkd(2001), 2'b11, 1, 2, 3);
        cy(2'b01, mkd(2063), NUL, 2);
        for (int j = 0; j <= 30; j++) begin
            ex("drain", 62 - 2 * j, mkd(2002 + 2 * j), mkd(2003 + 2 * j), 2'b11, 0, 0, 0);
            cy(2'b00, NUL, NUL, 2);
        end

        // Walk head to 62 / tail to 63
        for (int i = 0; i <= 29; i++) begin
            ex("refill", 2 * i, NUL, NUL, 2'b00, 1, (3 + 2 * i) % 64, (4 + 2 * i) % 64);
            cy(2'b11, mkd(3000 + 2 * i), mkd(3001 + 2 * i), 0);
        end
        for (int j = 0; j <= 28; j++) begin
            ex("trim", 60 - 2 * j, mkd(3000 + 2 * j), mkd(3001 + 2 * j), 2'b11, 0, 0, 0);
            cy(2'b00, NUL, NUL, 2);
        end
        ex("trim1", 2, mkd(3058), mkd(3059), 2'b11, 0, 0, 0); cy(2'b00, NUL, NUL, 1);

        // Push group straddling index 63 -> 0
        ex("wrap",   1, mkd(3059), NUL, 2'b01, 1, 63, 0); cy(2'b11, P, Q, 0);
        ex("wrap2",  3, mkd(3059), P,   2'b11, 1, 1, 1);  cy(2'b00, NUL, NUL, 1);
        ex("wrap3",  2, P,         Q,   2'b11, 0, 0, 0);  cy(2'b00, NUL, NUL, 2);

        // Build 10 entries at head 5 / tail 15, with push+pop overlap
        ex("r1", 0, NUL,       NUL,       2'b00, 1, 1, 2);   cy(2'b11, mkd(101), mkd(102), 0);
        ex("r2", 2, mkd(101),  mkd(102),  2'b11, 1, 3, 4);   cy(2'b11, mkd(103), mkd(104), 2);
        ex("r3", 2, mkd(103),  mkd(104),  2'b11, 1, 5, 6);   cy(2'b11, mkd(105), mkd(106), 2);
        ex("r4", 2, mkd(105),  mkd(106),  2'b11, 1, 7, 8);   cy(2'b11, mkd(107), mkd(108), 0);
        ex("r5", 4, mkd(105),  mkd(106),  2'b11, 1, 9, 10);  cy(2'b11, mkd(109), mkd(110), 0);
        ex("r6", 6, mkd(105),  mkd(106),  2'b11, 1, 11, 12); cy(2'b11, mkd(111), mkd(112), 0);
        ex("r7", 8, mkd(105),  mkd(106),  2'b11, 1, 13, 14); cy(2'b11, mkd(113), mkd(114), 0);

        // Recovery with a simultaneous (ignored) push and a pop
        ex("recover", 10, mkd(105), mkd(106), 2'b11, 1, 15, 16);
        cy(2'b11, X, Y, 1, 1'b1, 9);
        ex("recovered", 3, mkd(106), mkd(107), 2'b11, 1, 9, 10);
        cy(2'b11, Z0, Z1, 0);
        ex("post", 5, mkd(106), mkd(107), 2'b11, 1, 11, 11);
        cy(2'b00, NUL, NUL, 2);

        // Reset in the middle of push + pop
        ex("midrst",  3, mkd(108), Z0, 2'b11, 1, 11, 12);
        cy(2'b11, X, Y, 2, 1'b0, 0, 1'b1);
        ex("afterrst", 0, NUL, NUL, 2'b00, 1, 0, 0); cy(2'b00, NUL, NUL, 0);
        ex("idle",     0, NUL, NUL, 2'b00, 1, 0, 0); cy(2'b00, NUL, NUL, 0);

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            n_total++;
            $display("FAIL scoreboard_drain actual=%0d pending required=0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/active_list_queue.md
Name: active_list_queue

Overview:
- In-order circular queue that holds renamed ops from allocation to retirement.
- The rename side pushes up to RENAME_WIDTH entries per cycle at the tail and gets a pointer for each push.
- The commit side reads and pops up to COMMIT_WIDTH entries per cycle at the head.
- Reports occupancy and allocatability to rename and serialization logic; supports tail rollback on branch/exception recovery.

Parameters:
- RENAME_WIDTH, 2, maximum pushes per cycle.
- COMMIT_WIDTH, 2, maximum pops per cycle.
- ENTRY_NUM, 64, queue depth; power of two, >= RENAME_WIDTH + COMMIT_WIDTH.
- ENTRY_WIDTH, 96, packed payload bits per entry.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- pushTail  in  RENAME_WIDTH  per-lane push request; lanes may be non-contiguous.
- pushedTailData  in  RENAME_WIDTH*ENTRY_WIDTH  per-lane payload.
- pushedTailPtr  out  RENAME_WIDTH*log2(ENTRY_NUM)  index assigned to each lane, combinational.
- allocatable  out  1  free entries >= RENAME_WIDTH.
- validEntryNum  out  log2(ENTRY_NUM)+1  occupied entry count.
- headData  out  COMMIT_WIDTH*ENTRY_WIDTH  entries head+0 .. head+COMMIT_WIDTH-1, combinational read.
- headValid  out  COMMIT_WIDTH  lane k valid iff validEntryNum > k.
- popHeadNum  in  log2(COMMIT_WIDTH)+1  entries retired this cycle.
- recover  in  1  roll back the tail.
- recoverTailPtr  in  log2(ENTRY_NUM)+1  new tail, including wrap bit.

Behaviour:
- State: headPtr and tailPtr, each log2(ENTRY_NUM)+1 bits, MSB is the wrap bit. Payload RAM has ENTRY_NUM x ENTRY_WIDTH.
- Occupancy: validEntryNum = tailPtr - headPtr, modular over the full pointer width. Empty when pointers are equal; full when the low bits are equal and the wrap bits differ.
- Reset values: headPtr = tailPtr = 0, so validEntryNum = 0, allocatable = 1, headValid = 0. RAM contents are don't-care.
- Push pointer assignment: lane i receives tailPtr + (number of set pushTail bits in lanes 0..i-1), low bits only. pushedTailPtr is driven for every lane regardless of pushTail.
- Push timing: on the clock edge, pushed lanes write the RAM at their assigned pointers. tailPtr advances by popcount(pushTail). Data is readable at the head from the next cycle.
- Pop timing: headPtr advances by popHeadNum.
- Simultaneous push and pop: both apply in the same cycle. validEntryNum(next) = validEntryNum + pushes - pops.
- Pop overflow: popHeadNum > validEntryNum is illegal. Assertion fires; the pop is clamped to validEntryNum.
- Push overflow: pushing more than the free count (ENTRY_NUM - validEntryNum) is illegal. Assertion fires; the whole push group is dropped and tailPtr is unchanged.
- allocatable: combinational from registered state only. No dependency on pushTail or pops, so the controller stall path has no loop.
- Recovery: when recover=1, tailPtr(next) = recoverTailPtr and all pushes that cycle are ignored (no RAM write). popHeadNum is still applied to headPtr.
- Legal recoverTailPtr: must lie in [headPtr(next), tailPtr] in modular order; an assertion checks this. recoverTailPtr == headPtr(next) empties the queue.
- Wrap-around: pointer arithmetic wraps naturally. A push group may straddle index ENTRY_NUM-1 → 0, with each lane writing its own wrapped index.
- Reset mid-operation: rst has priority over recover, push and pop. Pointers return to 0 on that edge.
- Latency: push → headData visible 1 cycle later. Pop → validEntryNum reflects it 1 cycle later.

Decomposition:
- Shared package ActiveListTypes holds:
  - ActiveListIndexPath and ActiveListIndexWrapPath (pointer without and with wrap bit).
  - ActiveListCountPath.
  - The packed ActiveListEntry payload, whose width sets ENTRY_WIDTH.
  - Constants ACTIVE_LIST_ENTRY_NUM, RENAME_WIDTH, COMMIT_WIDTH.
- Sub-module multi_port_ring_ram holds the payload storage: RENAME_WIDTH write ports and COMMIT_WIDTH asynchronous read ports.
- Pointer, count and assertion logic stay in the top module.

Test Plan:
- Reset, then push lanes {1,1} with payloads A,B → pushedTailPtr = 0,1; next cycle validEntryNum = 2, headValid = 11, headData = A,B.
- Push lanes {0,1} with payload C → lane 1 gets pointer tailPtr+0; tail advances by 1; C appears at the head slot after A,B.
- Fill to ENTRY_NUM-1 entries → allocatable = 0. In the same cycle pop 2 and push 1 → next validEntryNum = ENTRY_NUM-2 and allocatable = 1.
- Start with head = 62, tail = 63 (ENTRY_NUM = 64); push 2 → lane pointers 63,0 and the tail wrap bit toggles; pop 3 over the next cycles returns the data in order.
- With 10 entries from head 5 (tail 15), assert recover with recoverTailPtr = 9, pushTail = 11 and popHeadNum = 1 → next head = 6, tail = 9, validEntryNum = 3, no RAM write.
- Raise rst during a cycle with push = 11 and pop = 2 → next cycle validEntryNum = 0, allocatable = 1, headValid = 00.
